// File: rtl/led_counter_display.sv
// LED heartbeat counter: WIDTH-bit counter with a programmable tap window driving
// NUM_LEDS indicators in binary, Gray, bouncing-scanner or blink mode.
// Optional macro LED_COUNTER_DISPLAY_ACTIVE_LOW_EN inverts led (lit on low, off = all ones).
module led_counter_display #(
  parameter int unsigned WIDTH       = 30,
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned TAP_DEFAULT = WIDTH - NUM_LEDS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [1:0]               mode,
  input  logic [$clog2(WIDTH)-1:0] tap_sel,
  input  logic                     tap_load,
  output logic [WIDTH-1:0]         count,
  output logic [NUM_LEDS-1:0]      led,
  output logic                     wrap,
  output logic                     step
);

  localparam int unsigned TAP_W   = $clog2(WIDTH);
  localparam int unsigned MAX_TAP = WIDTH - NUM_LEDS;
  localparam int unsigned POS_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

`ifdef LED_COUNTER_DISPLAY_ACTIVE_LOW_EN
  localparam logic [NUM_LEDS-1:0] LED_OFF = '1;
`else
  localparam logic [NUM_LEDS-1:0] LED_OFF = '0;
`endif

  logic [TAP_W-1:0]    tap;
  logic [POS_W-1:0]    pos;
  logic                dir_down;

  logic                inc_c;
  logic                tick_c;
  logic                roll_c;
  logic [WIDTH-1:0]    low_mask_c;
  logic [NUM_LEDS-1:0] slice_c;
  logic [NUM_LEDS-1:0] led_val_c;
  logic [WIDTH-1:0]    count_next;
  logic [TAP_W-1:0]    tap_next;
  logic [POS_W-1:0]    pos_next;
  logic                dir_next;

  // Increment qualification, tick detection and the displayed slice
  always_comb begin
    inc_c      = enable & ~clear;
    low_mask_c = ~({WIDTH{1'b1}} << tap);
    tick_c     = inc_c && ((count & low_mask_c) == low_mask_c);
    roll_c     = inc_c && (count == '1);
    slice_c    = NUM_LEDS'(count >> tap);
  end

  // Counter and tap next-state; out-of-range tap requests are dropped
  always_comb begin
    count_next = count;
    tap_next   = tap;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count + WIDTH'(1);
    end
    if (tap_load && (32'(tap_sel) <= MAX_TAP)) begin
      tap_next = tap_sel;
    end
  end

  // Bouncing scanner: reverse direction upon reaching either end
  always_comb begin
    pos_next = pos;
    dir_next = dir_down;
    if (clear) begin
      pos_next = '0;
      dir_next = 1'b0;
    end else if (tick_c && (NUM_LEDS > 1)) begin
      if (!dir_down) begin
        pos_next = pos + POS_W'(1);
        if (pos_next == POS_LAST) dir_next = 1'b1;
      end else begin
        pos_next = pos - POS_W'(1);
        if (pos_next == '0) dir_next = 1'b0;
      end
    end
  end

  // Display pattern selected by mode, from the pre-edge count and position
  always_comb begin
    led_val_c = '0;
    case (mode)
      2'b00:   led_val_c = slice_c;
      2'b01:   led_val_c = slice_c ^ (slice_c >> 1);
      2'b10:   led_val_c = NUM_LEDS'(1) << pos;
      default: led_val_c = {NUM_LEDS{slice_c[NUM_LEDS-1]}};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      tap      <= TAP_W'(TAP_DEFAULT);
      pos      <= '0;
      dir_down <= 1'b0;
      wrap     <= 1'b0;
      step     <= 1'b0;
      led      <= LED_OFF;
    end else begin
      count    <= count_next;
      tap      <= tap_next;
      pos      <= pos_next;
      dir_down <= dir_next;
      wrap     <= roll_c;
      step     <= tick_c;
      led      <= led_val_c ^ LED_OFF;
    end
  end

endmodule

// File: tb/tb_led_counter_display.sv
// Bench for led_counter_display (WIDTH=8, NUM_LEDS=4, TAP_DEFAULT=4): directed scenarios
// plus randomized traffic against a per-cycle arithmetic reference model.
module tb_led_counter_display;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned NUM_LEDS    = 4;
  localparam int unsigned TAP_DEFAULT = 4;

`ifdef LED_COUNTER_DISPLAY_ACTIVE_LOW_EN
  localparam logic [3:0] INV = 4'hF;
`else
  localparam logic [3:0] INV = 4'h0;
`endif

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       enable   = 1'b0;
  logic       clear    = 1'b0;
  logic [1:0] mode     = 2'b00;
  logic [2:0] tap_sel  = 3'd0;
  logic       tap_load = 1'b0;
  logic [7:0] count;
  logic [3:0] led;
  logic       wrap;
  logic       step;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int         m_count = 0;
  int         m_tap   = 4;
  int         m_ticks = 0;
  bit         m_inc;
  logic [3:0] e_led   = INV;
  logic       e_wrap  = 1'b0;
  logic       e_step  = 1'b0;

  led_counter_display #(
    .WIDTH(WIDTH), .NUM_LEDS(NUM_LEDS), .TAP_DEFAULT(TAP_DEFAULT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .mode(mode),
    .tap_sel(tap_sel), .tap_load(tap_load), .count(count), .led(led),
    .wrap(wrap), .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scanner position follows a 0,1,2,3,2,1 cycle indexed by the number of ticks since clear
  function automatic logic [3:0] model_led(input int cnt, input int tap, input int ticks,
                                           input logic [1:0] md);
    int s, k, p;
    s = (cnt >> tap) % 16;
    k = ticks % 6;
    p = (k < 4) ? k : 6 - k;
    case (md)
      2'd0:    return 4'(s) ^ INV;
      2'd1:    return 4'(s ^ (s >> 1)) ^ INV;
      2'd2:    return 4'(1 << p) ^ INV;
      default: return ((s >= 8) ? 4'hF : 4'h0) ^ INV;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0; m_tap = 4; m_ticks = 0;
      e_led = INV; e_wrap = 1'b0; e_step = 1'b0;
    end else begin
      m_inc  = enable && !clear;
      e_led  = model_led(m_count, m_tap, m_ticks, mode);
      e_wrap = m_inc && (m_count == 255);
      e_step = m_inc && ((m_count % (1 << m_tap)) == (1 << m_tap) - 1);
      if (clear) begin
        m_count = 0;
        m_ticks = 0;
      end else if (enable) begin
        if (e_step) m_ticks++;
        m_count = (m_count + 1) % 256;
      end
      if (tap_load && (int'(tap_sel) <= 4)) m_tap = int'(tap_sel);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("count", count, 32'(m_count));
      check("led",   led,   e_led);
      check("wrap",  wrap,  e_wrap);
      check("step",  step,  e_step);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  int         wraps;
  logic [3:0] sweep [7];

  initial begin
    sweep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    #3;
    check("rst_count", count, 0);
    check("rst_led", led, INV);
    check("rst_wrap", wrap, 0);
    check("rst_step", step, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 16 increments from zero
    enable = 1'b1;
    run(16);
    check("s1_count", count, 8'h10);
    check("s1_step", step, 1);
    check("s1_wrap", wrap, 0);
    enable = 1'b0;
    run(1);
    check("s1_led", led, 4'b0001 ^ INV);
    check("s1_step_off", step, 0);

    // Full roll-over, then clear colliding with a roll-over
    clear = 1'b1; run(1); clear = 1'b0;
    enable = 1'b1;
    wraps = 0;
    for (int i = 0; i < 256; i++) begin
      run(1);
      if (wrap) wraps++;
    end
    check("s2_wraps", wraps, 1);
    check("s2_count", count, 0);
    run(255);
    check("s2_ff", count, 8'hFF);
    clear = 1'b1; run(1); clear = 1'b0;
    check("s2_clr_count", count, 0);
    check("s2_clr_wrap", wrap, 0);
    enable = 1'b0;

    // Tap 2, then an out-of-range tap request
    tap_sel = 3'd2; tap_load = 1'b1; clear = 1'b1; run(1);
    tap_load = 1'b0; clear = 1'b0;
    enable = 1'b1; run(4); enable = 1'b0; run(1);
    check("s3_led", led, 4'b0001 ^ INV);
    tap_sel = 3'd5; tap_load = 1'b1; run(1); tap_load = 1'b0; run(1);
    check("s3_badtap_led", led, 4'b0001 ^ INV);

    // Gray at 0x30, blink at 0x80
    tap_sel = 3'd4; tap_load = 1'b1; clear = 1'b1; run(1);
    tap_load = 1'b0; clear = 1'b0; mode = 2'b01;
    enable = 1'b1; run(8'h30); enable = 1'b0; run(1);
    check("s4_gray", led, 4'b0010 ^ INV);
    enable = 1'b1; run(8'h50); enable = 1'b0;
    check("s4_count", count, 8'h80);
    mode = 2'b11; run(1);
    check("s4_blink", led, 4'b1111 ^ INV);

    // Scanner sweep at tap 0, then clear mid-sweep
    mode = 2'b10; tap_sel = 3'd0; tap_load = 1'b1; clear = 1'b1; run(1);
    tap_load = 1'b0; clear = 1'b0; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run(1);
      check("s5_sweep", led, sweep[i] ^ INV);
    end
    run(2);
    clear = 1'b1; run(1); clear = 1'b0; run(1);
    check("s5_clear", led, 4'b0001 ^ INV);

    // Asynchronous reset between clock edges
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("s6_count", count, 0);
    check("s6_led", led, INV);
    check("s6_wrap", wrap, 0);
    check("s6_step", step, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(1);
    check("s6_resume", count, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 63) == 0);
      tap_load = ($urandom_range(0, 31) == 0);
      tap_sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      run(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/led_counter_display.md
Name: led_counter_display

Overview:
Parametrised synchronous successor to the free-running LED heartbeat counter. It is a single-clock WIDTH-bit counter with a programmable tap window that drives NUM_LEDS indicator outputs. Four display modes are provided: binary, Gray, bouncing scanner and blink. It sits in the top level between a clock domain of interest (e.g. kernel_clk) and the board LEDs.

Parameters:
WIDTH, 30, counter width; legal range NUM_LEDS+1..32.
NUM_LEDS, 4, number of LED outputs; legal range 1..8.
TAP_DEFAULT, WIDTH-NUM_LEDS, reset value of the tap (LSB index of the displayed slice).

Ports:
clk  input  1  sole clock; all state changes on rising edge.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  count increment enable.
clear  input  1  synchronous clear of counter and scanner state.
mode  input  2  display mode: 00 binary, 01 Gray, 10 scanner, 11 blink.
tap_sel  input  $clog2(WIDTH)  requested tap index.
tap_load  input  1  load tap_sel into the tap register.
count  output  WIDTH  current counter value.
led  output  NUM_LEDS  registered LED drive.
wrap  output  1  one-cycle pulse on counter roll-over.
step  output  1  one-cycle pulse when the displayed slice advances.

Behaviour:
- Reset (async, reset_n=0) takes effect immediately, independent of clk:
  - count=0, tap=TAP_DEFAULT, scanner pos=0, dir=up.
  - wrap=0, step=0.
  - led = all logical-off (see Optional Feature for polarity).
- Counter:
  - clear=1 → count<=0 next edge; clear has priority over enable.
  - else enable=1 → count<=count+1, modulo 2^WIDTH.
  - else count holds.
- wrap: registered; 1 for exactly one cycle after an enabled increment from all-ones to 0. A clear never produces wrap.
- tick (internal): an enabled, non-cleared increment where count[tap-1:0] is all ones. For tap=0 every enabled increment is a tick.
- step: registered copy of tick; 1-cycle latency.
- Tap register:
  - tap_load=1 and tap_sel<=WIDTH-NUM_LEDS → tap<=tap_sel.
  - Out-of-range tap_sel is ignored; tap is unchanged.
  - The new tap applies from the next cycle.
- slice = count[tap +: NUM_LEDS], taken combinationally from the current count.
- Scanner state:
  - pos (0..NUM_LEDS-1) and dir advance on every tick regardless of mode.
  - dir=up: pos+1; when pos reaches NUM_LEDS-1, dir flips to down.
  - dir=down: pos-1; when pos reaches 0, dir flips to up.
  - NUM_LEDS=1: pos stays 0.
  - clear sets pos=0, dir=up.
- LED output, registered every cycle, 1-cycle latency from count/pos:
  - mode 00: led<=slice.
  - mode 01: led<=slice^(slice>>1).
  - mode 10: led<=one-hot(pos).
  - mode 11: every bit of led <= slice[NUM_LEDS-1].
  - A mode change takes effect on the next edge with no glitch cycle.
- Reset asserted mid-count aborts all state immediately. On reset_n release, counting resumes from 0 on the first enabled edge.

Optional Feature:
LED_COUNTER_DISPLAY_ACTIVE_LOW_EN.
- Defined: led output is bitwise inverted; logical-off (including the reset value) = all ones. This matches board LEDs that are lit on low.
- Undefined: led is active-high; reset value all zeros.
- count, wrap and step are unaffected in both cases.

Test Plan:
(All with WIDTH=8, NUM_LEDS=4, TAP_DEFAULT=4, macro undefined unless stated.)
1. Release reset, hold enable=1 for 16 cycles → count=0x10; one step pulse; led=0001 one cycle later; wrap stays 0.
2. Run enable for 256 cycles from 0 → exactly one wrap pulse, in the cycle after count goes 0xFF→0x00. Also: clear=1 together with enable while count=0xFF → count=0x00, no wrap.
3. tap_load with tap_sel=2, then 4 enabled increments from 0 → led=0001. Then tap_load with tap_sel=5 → tap stays 2.
4. mode=01, tap=4, count=0x30 (slice=3) → led=0010. Switch to mode=11 at count=0x80 → led=1111.
5. mode=10, tap=0, enable continuous → led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001; clear mid-sweep → 0001 next cycle.
6. Assert reset_n=0 asynchronously mid-count → count, led, wrap and step go to 0 without a clk edge. Repeat with LED_COUNTER_DISPLAY_ACTIVE_LOW_EN defined → led=1111 in reset, and led=1110 at scenario 1's endpoint.
